counter_sequencer: RTL and testbench
====================================

COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the counter width in bits.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low (0 = reset).
REQ-004 SHALL have port cmd_valid, input, 1 bit: a command is presented.
REQ-005 SHALL have port cmd_ready, output, 1 bit: the sequencer can accept a command.
REQ-006 SHALL have port cmd_op, input, 2 bits: 00 count up, 01 count down, 10 load, 11 nop.
REQ-007 SHALL have port cmd_len, input, WIDTH bits: step count for up/down; load value for load.
REQ-008 SHALL have port cmd_wrap, input, 1 bit: 1 = wrap at boundaries, 0 = saturate.
REQ-009 SHALL have port pause, input, 1 bit: freeze stepping while high.
REQ-010 SHALL have port abort, input, 1 bit: cancel the command in progress.
REQ-011 SHALL have port count, output, WIDTH bits: current counter value.
REQ-012 SHALL have port busy, output, 1 bit: high in RUN state.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse on command completion.
REQ-014 SHALL have port sat, output, 1 bit: sticky; a step was blocked by saturation.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE; cmd_ready = 1 only in IDLE; busy = 1 only in RUN; done = 1 only in DONE.
REQ-016 SHALL accept a command on a rising edge where cmd_valid = 1 and cmd_ready = 1; acceptance SHALL latch op, len and wrap and clear sat.
REQ-017 For up/down with len > 0, acceptance SHALL move the state to RUN with remaining = len.
REQ-018 Each RUN edge with pause = 0 SHALL step count by ±1 and decrement remaining; the edge where remaining = 1 SHALL move the state to DONE.
REQ-019 Latency SHALL be len+1 edges from acceptance to done high; for example, len = 3 updates count on edges k+1..k+3 and done is high between edges k+3 and k+4.
REQ-020 Up/down with len = 0, load, and nop SHALL go IDLE→DONE on the acceptance edge; load SHALL set count = cmd_len on that edge; nop SHALL leave count unchanged.
REQ-021 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-022 At a boundary (up at 2^WIDTH−1, down at 0): with wrap = 1, count SHALL wrap modulo 2^WIDTH; with wrap = 0, count SHALL hold, sat SHALL set, and the step SHALL still be consumed.
REQ-023 With pause = 1 in RUN, count and remaining SHALL hold; pause SHALL have no effect in IDLE or DONE.
REQ-024 With abort = 1 in RUN or DONE, the next edge SHALL go to IDLE with count held and no done pulse; abort SHALL have priority over pause and completion; in IDLE, abort SHALL be ignored.
REQ-025 Commands presented outside IDLE SHALL NOT be accepted, and the presenter SHALL hold them until cmd_ready.

Reset
REQ-026 While rst = 0, the block SHALL immediately hold state = IDLE, count = 0, remaining = 0, sat = 0, done = 0, busy = 0, cmd_ready = 1.
REQ-027 Reset asserted mid-RUN SHALL abandon the command with no done pulse; after rst rises, the first accept SHALL occur on the first clock edge.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE/RUN/DONE), the cmd_op encodings, and the default WIDTH.
REQ-029 The counter datapath SHALL be one sub-module, updown_count_core, with load/enable/up/wrap inputs and sat-detect output; the FSM SHALL stay in counter_sequencer.

Verification
REQ-030 Reset, then up, len = 5, wrap = 0 from 0 -> count 1..5 on consecutive edges, done one cycle at edge 6, cmd_ready back the cycle after.
REQ-031 Load 14, then up, len = 3, wrap = 1 -> count 15, 0, 1; sat = 0.
REQ-032 Load 1, then down, len = 3, wrap = 0 -> count 0, 0, 0; sat = 1 until the next accept; done after 3 steps.
REQ-033 Up, len = 4, pause high for 2 cycles after the 2nd step -> count 1, 2, 2, 2, 3, 4; done at edge 7.
REQ-034 Up, len = 8, abort at the 3rd RUN edge together with pause = 1 -> IDLE next edge, count = 2, no done pulse.
REQ-035 Up, len = 6, rst pulled low after 2 steps -> count = 0 and state IDLE immediately, no done; a new command is accepted on the first edge after release.

Source files
------------

// File: rtl/counter_sequencer_pkg.sv
// Shared definitions for the counter sequencer: FSM state encoding,
// command opcodes and the default counter width.
package counter_sequencer_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_UP   = 2'b00;
    localparam logic [1:0] OP_DOWN = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    // Only up/down commands spend cycles in RUN; everything else completes at once.
    function automatic logic is_step_op(input logic [1:0] op);
        return (op == OP_UP) || (op == OP_DOWN);
    endfunction

endpackage

// File: rtl/updown_count_core.sv
// Up/down counter datapath with parallel load and wrap-or-saturate stepping.
// o_sat_hit flags a step that was swallowed at a boundary in saturate mode.
module updown_count_core
    import counter_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    input  logic             i_up,
    input  logic             i_wrap,
    output logic [WIDTH-1:0] o_count,
    output logic             o_sat_hit
);

    logic [WIDTH-1:0] r_count;
    logic             w_at_max;
    logic             w_at_min;
    logic             w_blocked;

    assign w_at_max  = &r_count;
    assign w_at_min  = ~|r_count;
    assign w_blocked = i_en & ~i_wrap & (i_up ? w_at_max : w_at_min);

    // Wrapping falls out of plain modulo arithmetic; only saturation needs a guard.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && !w_blocked) begin
            r_count <= i_up ? r_count + 1'b1 : r_count - 1'b1;
        end
    end

    assign o_count   = r_count;
    assign o_sat_hit = w_blocked;

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven counter sequencer: accepts up/down/load/nop commands in IDLE,
// steps the counter once per unpaused RUN cycle and pulses done for one cycle.
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_len,
    input  logic             cmd_wrap,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             sat
);

    state_t           r_state;
    state_t           w_next_state;
    logic [1:0]       r_op;
    logic             r_wrap;
    logic [WIDTH-1:0] r_remaining;
    logic             r_sat;

    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic             w_sat_hit;

    assign w_accept = cmd_valid & (r_state == ST_IDLE);
    assign w_step   = (r_state == ST_RUN) & ~abort & ~pause;
    assign w_last   = (r_remaining == WIDTH'(1));

    // Abort outranks both pause and completion while a command is active.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = (is_step_op(cmd_op) && (cmd_len != '0)) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (!pause && w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_NOP;
            r_wrap      <= 1'b0;
            r_remaining <= '0;
            r_sat       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_op        <= cmd_op;
                r_wrap      <= cmd_wrap;
                r_remaining <= is_step_op(cmd_op) ? cmd_len : '0;
                r_sat       <= 1'b0;
            end else begin
                if ((r_state == ST_RUN) && abort) begin
                    r_remaining <= '0;
                end else if (w_step) begin
                    r_remaining <= r_remaining - 1'b1;
                end
                if (w_sat_hit) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    updown_count_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_load     (w_accept & (cmd_op == OP_LOAD)),
        .i_load_val (cmd_len),
        .i_en       (w_step),
        .i_up       (r_op == OP_UP),
        .i_wrap     (r_wrap),
        .o_count    (count),
        .o_sat_hit  (w_sat_hit)
    );

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_RUN);
    assign done      = (r_state == ST_DONE);
    assign sat       = r_sat;

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: a table of commands scored through
// an expected-result queue, plus hand-written pause, abort and reset sequences.
module tb_counter_sequencer;

    localparam logic [1:0] OP_UP   = 2'b00;
    localparam logic [1:0] OP_DOWN = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    typedef struct {
        logic [1:0] op;
        logic [3:0] len;
        logic       wrap;
        logic [3:0] expCount;
        logic       expSat;
        int         expLat;
    } vec_t;

    typedef struct {
        logic [3:0] count;
        logic       sat;
        int         lat;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_len;
    logic       cmd_wrap;
    logic       pause;
    logic       abort;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic       sat;

    int   nCompared;
    int   nFailed;
    exp_t sbQ[$];
    vec_t vecs[10];

    counter_sequencer #(
        .WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_wrap  (cmd_wrap),
        .pause     (pause),
        .abort     (abort),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .sat       (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for cmd_ready, presents one command for the accepting edge.
    task automatic issueCmd(input logic [1:0] op, input logic [3:0] len, input logic wrap);
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 40) begin
            stepEdge();
            guard++;
        end
        if (!cmd_ready) checkOutput("readyTimeout", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_wrap  = wrap;
        stepEdge();
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        e.count = v.expCount;
        e.sat   = v.expSat;
        e.lat   = v.expLat;
        sbQ.push_back(e);
        issueCmd(v.op, v.len, v.wrap);
    endtask

    // Latency counts the accept edge as 1; called just after that edge.
    task automatic waitDone(output int lat, output bit ok);
        lat = 1;
        ok  = 1'b1;
        while (!done) begin
            if (lat > 40) begin
                ok = 1'b0;
                break;
            end
            stepEdge();
            lat++;
        end
    endtask

    task automatic finishCmd();
        int lat;
        bit ok;
        waitDone(lat, ok);
        if (!ok) checkOutput("doneTimeout", 32'd0, 32'd1);
        stepEdge();
    endtask

    initial begin
        int   lat;
        bit   ok;
        exp_t e;

        nCompared = 0;
        nFailed   = 0;

        vecs[0] = '{OP_UP,   4'd5,  1'b0, 4'd5,  1'b0, 6};
        vecs[1] = '{OP_LOAD, 4'd14, 1'b0, 4'd14, 1'b0, 1};
        vecs[2] = '{OP_UP,   4'd3,  1'b1, 4'd1,  1'b0, 4};
        vecs[3] = '{OP_LOAD, 4'd1,  1'b0, 4'd1,  1'b0, 1};
        vecs[4] = '{OP_DOWN, 4'd3,  1'b0, 4'd0,  1'b1, 4};
        vecs[5] = '{OP_NOP,  4'd7,  1'b0, 4'd0,  1'b0, 1};
        vecs[6] = '{OP_DOWN, 4'd0,  1'b1, 4'd0,  1'b0, 1};
        vecs[7] = '{OP_DOWN, 4'd2,  1'b1, 4'd14, 1'b0, 3};
        vecs[8] = '{OP_UP,   4'd3,  1'b0, 4'd15, 1'b1, 4};
        vecs[9] = '{OP_LOAD, 4'd0,  1'b1, 4'd0,  1'b0, 1};

        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_len   = 4'd0;
        cmd_wrap  = 1'b0;
        pause     = 1'b0;
        abort     = 1'b0;

        #2;
        checkOutput("rstCount", 32'(count), 32'd0);
        checkOutput("rstReady", 32'(cmd_ready), 32'd1);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstSat", 32'(sat), 32'd0);
        #10 rst = 1'b1;
        stepEdge();

        abort = 1'b1;
        stepEdge();
        checkOutput("idleAbortReady", 32'(cmd_ready), 32'd1);
        abort = 1'b0;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            waitDone(lat, ok);
            e = sbQ.pop_front();
            if (!ok) checkOutput($sformatf("vec%0d.doneTimeout", i), 32'd0, 32'd1);
            checkOutput($sformatf("vec%0d.latency", i), 32'(lat), 32'(e.lat));
            checkOutput($sformatf("vec%0d.count", i), 32'(count), 32'(e.count));
            checkOutput($sformatf("vec%0d.sat", i), 32'(sat), 32'(e.sat));
            stepEdge();
            checkOutput($sformatf("vec%0d.doneDrop", i), 32'(done), 32'd0);
            checkOutput($sformatf("vec%0d.readyBack", i), 32'(cmd_ready), 32'd1);
            checkOutput($sformatf("vec%0d.satHeld", i), 32'(sat), 32'(e.sat));
        end
        checkOutput("sbEmpty", 32'(sbQ.size()), 32'd0);

        // Pause for two cycles after the second step
        issueCmd(OP_LOAD, 4'd0, 1'b0);
        finishCmd();
        issueCmd(OP_UP, 4'd4, 1'b0);
        checkOutput("pauseBusy", 32'(busy), 32'd1);
        stepEdge();
        checkOutput("pauseStep1", 32'(count), 32'd1);
        stepEdge();
        checkOutput("pauseStep2", 32'(count), 32'd2);
        pause = 1'b1;
        stepEdge();
        checkOutput("pauseHold1", 32'(count), 32'd2);
        stepEdge();
        checkOutput("pauseHold2", 32'(count), 32'd2);
        checkOutput("pauseBusyHeld", 32'(busy), 32'd1);
        pause = 1'b0;
        stepEdge();
        checkOutput("pauseStep3", 32'(count), 32'd3);
        checkOutput("pauseNoEarlyDone", 32'(done), 32'd0);
        stepEdge();
        checkOutput("pauseStep4", 32'(count), 32'd4);
        checkOutput("pauseDone", 32'(done), 32'd1);
        stepEdge();
        checkOutput("pauseDoneDrop", 32'(done), 32'd0);

        // Abort together with pause on the third RUN edge
        issueCmd(OP_LOAD, 4'd0, 1'b0);
        finishCmd();
        issueCmd(OP_UP, 4'd8, 1'b0);
        stepEdge();
        stepEdge();
        checkOutput("abortPre", 32'(count), 32'd2);
        abort = 1'b1;
        pause = 1'b1;
        stepEdge();
        abort = 1'b0;
        pause = 1'b0;
        checkOutput("abortReady", 32'(cmd_ready), 32'd1);
        checkOutput("abortBusy", 32'(busy), 32'd0);
        checkOutput("abortDone", 32'(done), 32'd0);
        checkOutput("abortCount", 32'(count), 32'd2);
        stepEdge();
        checkOutput("abortNoDoneLater", 32'(done), 32'd0);
        checkOutput("abortCountHeld", 32'(count), 32'd2);

        // Reset pulled mid-RUN, then accept on the first edge after release
        issueCmd(OP_LOAD, 4'd0, 1'b0);
        finishCmd();
        issueCmd(OP_UP, 4'd6, 1'b0);
        stepEdge();
        stepEdge();
        checkOutput("rstMidPre", 32'(count), 32'd2);
        #2 rst = 1'b0;
        #1;
        checkOutput("rstMidCount", 32'(count), 32'd0);
        checkOutput("rstMidReady", 32'(cmd_ready), 32'd1);
        checkOutput("rstMidBusy", 32'(busy), 32'd0);
        checkOutput("rstMidDone", 32'(done), 32'd0);
        #3 rst = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = OP_UP;
        cmd_len   = 4'd1;
        cmd_wrap  = 1'b0;
        stepEdge();
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        checkOutput("rstFirstAccept", 32'(busy), 32'd1);
        stepEdge();
        checkOutput("rstPostDone", 32'(done), 32'd1);
        checkOutput("rstPostCount", 32'(count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule
